// File: rtl/tft_pio_ctrl.sv
// tft_pio_ctrl: turns the HPS PIO word into panel reset sequencing, D/C select and backlight PWM
module tft_pio_ctrl #(
    parameter int RST_PULSE_CYCLES = 500000,
    parameter int RST_WAIT_CYCLES  = 6000000,
    parameter int PWM_BITS         = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pio_word,
    output logic        tft_rst_n,
    output logic        tft_dc,
    output logic        tft_bl_pwm,
    output logic [3:0]  status
);
    localparam int CMAX = (RST_PULSE_CYCLES > RST_WAIT_CYCLES) ? RST_PULSE_CYCLES : RST_WAIT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LD  = CW'(RST_WAIT_CYCLES - 1);

    typedef enum logic [1:0] {RST_ASSERT, RST_WAIT, READY} state_t;

    state_t              state_q, state_d;
    logic [31:0]         pio_q;
    logic                tog_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [1:0]          seq_q, seq_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d, duty_q, duty_d;
    logic                rst_n_q, rst_n_d, dc_q, dc_d, bl_q, bl_d, rdy_q, rdy_d;
    logic                req, ready;
    logic                unused_pio;

    assign unused_pio = ^{pio_q[31:11], pio_q[7:0]};

    always_comb begin
        req     = pio_q[9] ^ tog_q;
        ready   = state_q == READY;
        state_d = state_q;
        cnt_d   = cnt_q - 1'b1;
        pend_d  = pend_q | req;
        seq_d   = seq_q;
        case (state_q)
            RST_ASSERT: if (cnt_q == '0) begin
                state_d = RST_WAIT;
                cnt_d   = WAIT_LD;
            end
            RST_WAIT: if (cnt_q == '0) begin
                state_d = READY;
                seq_d   = seq_q + 2'd1;
            end
            default: begin
                // a fresh request and a stored one collapse into a single re-run
                pend_d = 1'b0;
                if (req || pend_q) begin
                    state_d = RST_ASSERT;
                    cnt_d   = PULSE_LD;
                end
            end
        endcase
        rst_n_d = state_q != RST_ASSERT;
        dc_d    = ready & pio_q[8];
        bl_d    = pio_q[10] & ready & (pwm_q < duty_q);
        rdy_d   = ready;
        pwm_d   = pwm_q + 1'b1;
        duty_d  = &pwm_q ? pio_q[PWM_BITS-1:0] : duty_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RST_ASSERT;
            cnt_q   <= PULSE_LD;
            pio_q   <= '0;
            tog_q   <= 1'b0;
            pend_q  <= 1'b0;
            seq_q   <= '0;
            pwm_q   <= '0;
            duty_q  <= '0;
            rst_n_q <= 1'b0;
            dc_q    <= 1'b0;
            bl_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pio_q   <= pio_word;
            tog_q   <= pio_q[9];
            pend_q  <= pend_d;
            seq_q   <= seq_d;
            pwm_q   <= pwm_d;
            duty_q  <= duty_d;
            rst_n_q <= rst_n_d;
            dc_q    <= dc_d;
            bl_q    <= bl_d;
            rdy_q   <= rdy_d;
        end
    end

    assign tft_rst_n  = rst_n_q;
    assign tft_dc     = dc_q;
    assign tft_bl_pwm = bl_q;
    assign status     = {seq_q, pend_q, rdy_q};
endmodule

// File: doc/tft_pio_ctrl.md
# tft_pio_ctrl

Control-line sequencer for the SPI TFT panel. It sits directly downstream of the HPS `adafruit_tft_pio` 32-bit export and turns the raw PIO word into timed panel signals: hardware reset pulse plus settle wait, D/C select, and a glitch-free backlight PWM. It also returns a small status word for HPS software to poll. It runs in the HPS-to-FPGA clock domain, the same domain that drives the PIO.

## Interface
- `RST_PULSE_CYCLES`, default 500000: cycles `tft_rst_n` is held low per reset sequence (10 ms at 50 MHz); must be ≥1.
- `RST_WAIT_CYCLES`, default 6000000: settle cycles after `tft_rst_n` rises, before READY (120 ms); must be ≥1.
- `PWM_BITS`, default 8: backlight PWM resolution; period is 2^PWM_BITS cycles.
- `clk`  in  1  block clock; same clock as the PIO source.
- `reset_n`  in  1  reset. Reset is synchronous and active-low.
- `pio_word`  in  32  PIO export. Fields: [PWM_BITS-1:0] duty; [8] dc; [9] reset-request toggle; [10] backlight enable. Other bits are ignored.
- `tft_rst_n`  out  1  panel hardware reset, active-low.
- `tft_dc`  out  1  panel data/command select.
- `tft_bl_pwm`  out  1  backlight PWM.
- `status`  out  4  [0] ready, [1] request pending, [3:2] completed-sequence count modulo 4.

## Operation
- Input stage: `pio_word` is registered into `pio_q` every cycle. `tog_d` holds the previous value of `pio_q[9]`. A request is `pio_q[9] != tog_d`, so every change of bit 9, rising or falling, is one request.
- FSM states: RST_ASSERT, RST_WAIT, READY.
  - Reset: state RST_ASSERT, so a power-on sequence always runs.
- Counter: one down-counter `cnt`, width clog2(max(RST_PULSE_CYCLES, RST_WAIT_CYCLES)+1).
- RST_ASSERT:
  - `tft_rst_n`=0.
  - `cnt` is loaded with RST_PULSE_CYCLES-1 on entry.
  - When `cnt`==0: move to RST_WAIT and load RST_WAIT_CYCLES-1.
- RST_WAIT:
  - `tft_rst_n`=1.
  - When `cnt`==0: move to READY and increment `status[3:2]`, wrapping 3→0.
- READY:
  - `tft_rst_n`=1.
  - A request or a pending flag moves the FSM to RST_ASSERT and clears pending.
- Requests arriving in RST_ASSERT or RST_WAIT set pending. Pending is one bit, so multiple requests merge into one re-run, which starts on the cycle after READY is entered.
- A request and pending=1 together in READY cause one sequence only.
- D/C: `tft_dc` <= `pio_q[8]` when state is READY, otherwise 0.
- PWM:
  - Free-running `pwm_cnt`, PWM_BITS wide, wrapping.
  - The duty register `duty_r` loads `pio_q[PWM_BITS-1:0]` only on the cycle where `pwm_cnt` is all-ones, so duty changes take effect at period boundaries.
  - `tft_bl_pwm` <= `pio_q[10]` && (state==READY) && (`pwm_cnt` < `duty_r`).
  - Duty 0 gives constant 0. Duty 2^PWM_BITS-1 gives high for all but 1 cycle per period.
  - The enable bit (bit 10) acts on the next cycle without waiting for a boundary.
- Reset mid-sequence: the sequence restarts from RST_ASSERT with a full pulse. Pending, `status[3:2]`, `pwm_cnt` and `duty_r` are all cleared.

## Timing
- Reset values while `reset_n`=0:
  - `tft_rst_n`=0, `tft_dc`=0, `tft_bl_pwm`=0, `status`=4'b0000.
  - `pio_q`=0, `tog_d`=0.
- Because `tog_d` resets to 0, a bit 9 of 1 at reset release counts as one request and becomes pending.
- Let cycle 0 be the first rising edge with `reset_n`=1:
  - `tft_rst_n` is low for cycles 0..RST_PULSE_CYCLES-1.
  - `tft_rst_n` is high from cycle RST_PULSE_CYCLES.
  - `status[0]` rises at cycle RST_PULSE_CYCLES+RST_WAIT_CYCLES.
- All outputs are registered.
- `pio_word` to `tft_dc` latency: 2 cycles.
- Request edge on `pio_word[9]` while READY: `tft_rst_n` falls 3 cycles after the input change (input register, edge detect, FSM).
- `status[1]` is set 2 cycles after an ignored-state request.

## Test plan
Bench parameters for all scenarios: RST_PULSE_CYCLES=4, RST_WAIT_CYCLES=8, PWM_BITS=4.
1. Power-on with `pio_word`=0 → `tft_rst_n` low for exactly 4 cycles, high thereafter; `status`=4'b0101 at cycle 12.
2. In READY, toggle bit 9 0→1 → `tft_rst_n` low 4 cycles starting 3 cycles later; `status[0]` low for 12 cycles; then `status[3:2]`=2.
3. Toggle bit 9 twice during RST_WAIT → `status[1]`=1, and exactly one extra sequence runs after READY; final `status[3:2]`=2.
4. READY, bit 10=1, duty=4 → `tft_bl_pwm` high 4 of every 16 cycles. Change duty to 12 mid-period → the current period keeps 4; the next period shows 12. Duty 0 → constantly low.
5. READY, write bit 8=1 → `tft_dc`=1 after 2 cycles. Trigger a reset request → `tft_dc`=0 and `tft_bl_pwm`=0 for the whole sequence.
6. Assert `reset_n` low for 1 cycle in the middle of RST_WAIT → all outputs take reset values, then a full 4+8-cycle sequence runs with `status[3:2]`=1 at its end.
